// File: rtl/ins_fetch.sv
// ---------------------------------------------------------------------------
// ins_fetch
//   Instruction fetch sequencer for a synchronous-read instruction memory.
//   Issues one read per instruction, captures the returned word, and offers
//   it downstream on a valid/ready handshake. On accept the PC either steps
//   sequentially (wrapping modulo 2**ADDR_WIDTH) or loads a jump target.
//   Fetching stops once the HALT instruction has been accepted.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | not running; waits for start
//   FETCH   | rEn=1 for one cycle at PC_address=pc
//   WAIT    | memory data returns; capture into ins_out / ins_pc
//   HOLD    | ins_valid=1 until the consumer accepts
//   HALTED  | HALT instruction accepted; done=1; waits for start
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        run control (abort wins over everything)
//   PC_address, rEn     instruction memory address / read enable
//   instruction         memory read data (one cycle after rEn)
//   ins_out, ins_pc     held instruction and the address it came from
//   ins_valid, ins_ready downstream handshake
//   jump_en, jump_addr  jump request, sampled only at accept
//   done                high while HALTED
//   fetch_count         instructions accepted since the last start
// ---------------------------------------------------------------------------
module ins_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    INS_WIDTH  = 9,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [INS_WIDTH-1:0]  HALT_INS   = 9'h1FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] PC_address,
  output logic                  rEn,
  input  logic [INS_WIDTH-1:0]  instruction,
  output logic [INS_WIDTH-1:0]  ins_out,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  done,
  output logic [15:0]           fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= START_ADDR;
      ins_out     <= '0;
      ins_pc      <= '0;
      fetch_count <= '0;
    end else if (abort) begin
      // ins_out, ins_pc and fetch_count are deliberately left intact
      state <= S_IDLE;
      pc    <= START_ADDR;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc          <= START_ADDR;
            fetch_count <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          ins_out <= instruction;
          ins_pc  <= pc;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          if (ins_ready) begin
            fetch_count <= fetch_count + 16'd1;
            // HALT is checked first so a jump can never escape it
            if (ins_out == HALT_INS) begin
              state <= S_HALTED;
            end else begin
              if (jump_en) pc <= jump_addr;
              else         pc <= pc + ADDR_WIDTH'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decode from the state register alone
  assign PC_address = pc;
  assign rEn        = (state == S_FETCH);
  assign ins_valid  = (state == S_HOLD);
  assign done       = (state == S_HALTED);

endmodule

// File: tb/tb_ins_fetch.sv
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  PC_address;
  logic        rEn;
  logic [8:0]  instruction = '0;
  logic [8:0]  ins_out;
  logic [7:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        done;
  logic [15:0] fetch_count;

  logic [8:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;

  ins_fetch #(
    .ADDR_WIDTH(8),
    .INS_WIDTH (9),
    .START_ADDR(8'h00),
    .HALT_INS  (9'h1FF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .PC_address (PC_address),
    .rEn        (rEn),
    .instruction(instruction),
    .ins_out    (ins_out),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .done       (done),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) if (rEn) instruction <= mem[PC_address];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    checks++; if ({rEn, ins_valid, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rEn, ins_valid, done}); end
    checks++; if (PC_address !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", PC_address); end
    checks++; if ({ins_out, ins_pc} !== 17'h0) begin errors++; $display("FAIL reset_ins: got %h/%h expected 000/00", ins_out, ins_pc); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [8:0] exp_ins [0:2];
    logic [7:0] exp_pc  [0:2];
    exp_ins = '{9'h001, 9'h002, 9'h003};
    exp_pc  = '{8'h00, 8'h01, 8'h02};
    ins_ready = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      start = 1'b0;
      checks++; if ({rEn, ins_valid, PC_address} !== {1'b1, 1'b0, exp_pc[k]}) begin errors++; $display("FAIL seq_fetch[%0d]: got rEn=%b valid=%b pc=%h expected 1/0/%h", k, rEn, ins_valid, PC_address, exp_pc[k]); end
      step();
      checks++; if ({rEn, ins_valid} !== 2'b00) begin errors++; $display("FAIL seq_wait[%0d]: got rEn=%b valid=%b expected 0/0", k, rEn, ins_valid); end
      step();
      checks++; if ({ins_valid, ins_out, ins_pc} !== {1'b1, exp_ins[k], exp_pc[k]}) begin errors++; $display("FAIL seq_hold[%0d]: got valid=%b ins=%h pc=%h expected 1/%h/%h", k, ins_valid, ins_out, ins_pc, exp_ins[k], exp_pc[k]); end
    end
    ins_ready = 1'b0;
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL seq_count: got %0d expected 2", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({ins_valid, rEn, ins_out, ins_pc, PC_address} !== {1'b1, 1'b0, 9'h003, 8'h02, 8'h02}) begin errors++; $display("FAIL stall[%0d]: got valid=%b rEn=%b ins=%h ipc=%h pc=%h expected 1/0/003/02/02", i, ins_valid, rEn, ins_out, ins_pc, PC_address); end
    end
    ins_ready = 1'b1;
    step();
    checks++; if ({rEn, PC_address, fetch_count} !== {1'b1, 8'h03, 16'd3}) begin errors++; $display("FAIL stall_release: got rEn=%b pc=%h cnt=%0d expected 1/03/3", rEn, PC_address, fetch_count); end
    step();
    step();
    checks++; if ({ins_valid, ins_out, ins_pc} !== {1'b1, 9'h004, 8'h03}) begin errors++; $display("FAIL stall_next: got valid=%b ins=%h pc=%h expected 1/004/03", ins_valid, ins_out, ins_pc); end
  endtask

  task automatic test_jump();
    jump_en = 1'b1;
    jump_addr = 8'h40;
    step();
    checks++; if ({rEn, PC_address} !== {1'b1, 8'h40}) begin errors++; $display("FAIL jump_fetch: got rEn=%b pc=%h expected 1/40", rEn, PC_address); end
    jump_en = 1'b0;
    jump_addr = 8'h13;
    step();
    step();
    checks++; if ({ins_valid, ins_out, ins_pc, fetch_count} !== {1'b1, 9'h041, 8'h40, 16'd4}) begin errors++; $display("FAIL jump_hold: got valid=%b ins=%h pc=%h cnt=%0d expected 1/041/40/4", ins_valid, ins_out, ins_pc, fetch_count); end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1;
    jump_addr = 8'hFF;
    step();
    checks++; if ({rEn, PC_address} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL wrap_jump: got rEn=%b pc=%h expected 1/ff", rEn, PC_address); end
    jump_en = 1'b0;
    step();
    step();
    checks++; if ({ins_valid, ins_out, ins_pc} !== {1'b1, 9'h100, 8'hFF}) begin errors++; $display("FAIL wrap_hold: got valid=%b ins=%h pc=%h expected 1/100/ff", ins_valid, ins_out, ins_pc); end
    step();
    checks++; if ({rEn, PC_address, fetch_count} !== {1'b1, 8'h00, 16'd6}) begin errors++; $display("FAIL wrap_pc: got rEn=%b pc=%h cnt=%0d expected 1/00/6", rEn, PC_address, fetch_count); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if ({rEn, ins_valid, done, PC_address} !== {3'b000, 8'h00}) begin errors++; $display("FAIL abort_fetch: got rEn=%b valid=%b done=%b pc=%h expected 0/0/0/00", rEn, ins_valid, done, PC_address); end
    checks++; if ({ins_out, ins_pc, fetch_count} !== {9'h100, 8'hFF, 16'd6}) begin errors++; $display("FAIL abort_keep: got ins=%h pc=%h cnt=%0d expected 100/ff/6", ins_out, ins_pc, fetch_count); end
  endtask

  task automatic test_halt();
    logic [8:0] exp_ins [0:3];
    exp_ins = '{9'h001, 9'h002, 9'h003, 9'h1FF};
    mem[3] = 9'h1FF;
    ins_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({rEn, PC_address, fetch_count} !== {1'b1, 8'h00, 16'd0}) begin errors++; $display("FAIL halt_start: got rEn=%b pc=%h cnt=%0d expected 1/00/0", rEn, PC_address, fetch_count); end
    for (int k = 0; k < 4; k++) begin
      step();
      step();
      checks++; if ({ins_valid, ins_out} !== {1'b1, exp_ins[k]}) begin errors++; $display("FAIL halt_hold[%0d]: got valid=%b ins=%h expected 1/%h", k, ins_valid, ins_out, exp_ins[k]); end
      if (k < 3) step();
    end
    step();
    checks++; if ({done, rEn, ins_valid, fetch_count} !== {3'b100, 16'd4}) begin errors++; $display("FAIL halt_done: got done=%b rEn=%b valid=%b cnt=%0d expected 1/0/0/4", done, rEn, ins_valid, fetch_count); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({done, rEn, PC_address} !== {2'b10, 8'h03}) begin errors++; $display("FAIL halt_idle[%0d]: got done=%b rEn=%b pc=%h expected 1/0/03", i, done, rEn, PC_address); end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if ({rEn, done, PC_address, fetch_count} !== {2'b10, 8'h00, 16'd0}) begin errors++; $display("FAIL halt_restart: got rEn=%b done=%b pc=%h cnt=%0d expected 1/0/00/0", rEn, done, PC_address, fetch_count); end
  endtask

  task automatic test_abort();
    step();
    step();
    checks++; if ({ins_valid, ins_out} !== {1'b1, 9'h001}) begin errors++; $display("FAIL abort_pre: got valid=%b ins=%h expected 1/001", ins_valid, ins_out); end
    abort = 1'b1;
    start = 1'b1;
    ins_ready = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    checks++; if ({ins_valid, rEn, done, PC_address, fetch_count, ins_out} !== {3'b000, 8'h00, 16'd0, 9'h001}) begin errors++; $display("FAIL abort_hold: got valid=%b rEn=%b done=%b pc=%h cnt=%0d ins=%h expected 0/0/0/00/0/001", ins_valid, rEn, done, PC_address, fetch_count, ins_out); end
    step();
    checks++; if ({rEn, ins_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle: got rEn=%b valid=%b expected 0/0", rEn, ins_valid); end
  endtask

  task automatic test_async_reset();
    mem[3] = 9'h004;
    ins_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    ins_ready = 1'b0;
    checks++; if ({ins_valid, ins_out, ins_pc, fetch_count} !== {1'b1, 9'h002, 8'h01, 16'd1}) begin errors++; $display("FAIL areset_pre: got valid=%b ins=%h pc=%h cnt=%0d expected 1/002/01/1", ins_valid, ins_out, ins_pc, fetch_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rEn, ins_valid, done, PC_address} !== {3'b000, 8'h00}) begin errors++; $display("FAIL areset_ctl: got rEn=%b valid=%b done=%b pc=%h expected 0/0/0/00", rEn, ins_valid, done, PC_address); end
    checks++; if ({ins_out, ins_pc, fetch_count} !== {9'h000, 8'h00, 16'd0}) begin errors++; $display("FAIL areset_data: got ins=%h pc=%h cnt=%0d expected 000/00/0", ins_out, ins_pc, fetch_count); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'(i + 1);
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_wrap();
    test_halt();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
